// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hazard_pkg
// Description : Shared types and constants for the pipeline hazard controller.
// Revision    : 1.0 - initial release
// ============================================================================
package hazard_pkg;

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MUL_BUSY = 1'b1
    } state_t;

    localparam int MUL_LAT_MIN = 2;
    localparam int MUL_LAT_MAX = 16;

    // sll $0,$0,0 -- the instruction word the pipeline registers load on a flush
    localparam logic [31:0] C_NOP_INSTR = 32'h0000_0000;

endpackage
`default_nettype wire

// File: rtl/hazard_ctrl_mul_busy_cnt.sv
`default_nettype none
// ============================================================================
// Module      : mul_busy_cnt
// Description : Multiply freeze countdown; loads MUL_LAT-1, flags last cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module mul_busy_cnt #(
    parameter int MUL_LAT = 4,
    parameter int CNT_W   = $clog2(MUL_LAT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             last
);

    localparam logic [CNT_W-1:0] C_LOAD_VAL = CNT_W'(MUL_LAT - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= C_LOAD_VAL;
        end else if (dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign cnt  = r_cnt;
    assign last = (r_cnt == CNT_W'(1));

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : Load-use stall, branch flush and multiply freeze control.
//               HAZARD_PERF_EN enables the stall/flush performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MUL_LAT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  ID_Rs,
    input  logic [4:0]  ID_Rt,
    input  logic        ID_uses_rt,
    input  logic        ID_is_mul,
    input  logic        EX_MemRead,
    input  logic [4:0]  EX_WR_out,
    input  logic        EX_branch_taken,
    output logic        PC_write,
    output logic        IF_ID_write,
    output logic        IF_ID_flush,
    output logic        ID_EX_write,
    output logic        ID_EX_flush,
    output logic        EX_M_bubble,
    output logic        mul_start,
    output logic        mul_busy,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
);

    localparam int CNT_W = $clog2(MUL_LAT);

    if ((MUL_LAT < MUL_LAT_MIN) || (MUL_LAT > MUL_LAT_MAX)) begin : g_bad_mul_lat
        $error("hazard_ctrl: MUL_LAT out of range");
    end

    state_t           r_state;
    logic [CNT_W-1:0] w_cnt;
    logic             w_last;
    logic             w_lu;
    logic             w_in_run;
    logic             w_in_busy;
    logic             w_issue_mul;
    logic             w_lu_stall;
    logic             w_branch_flush;

    assign w_lu = EX_MemRead && (EX_WR_out != 5'd0) &&
                  ((EX_WR_out == ID_Rs) || (ID_uses_rt && (EX_WR_out == ID_Rt)));

    assign w_in_run       = !rst && (r_state == RUN);
    assign w_in_busy      = !rst && (r_state == MUL_BUSY);
    assign w_branch_flush = w_in_run && EX_branch_taken;
    assign w_lu_stall     = w_in_run && !EX_branch_taken && w_lu;
    assign w_issue_mul    = w_in_run && !EX_branch_taken && !w_lu && ID_is_mul;

    mul_busy_cnt #(
        .MUL_LAT (MUL_LAT),
        .CNT_W   (CNT_W)
    ) u_mul_busy_cnt (
        .clk  (clk),
        .rst  (rst),
        .load (w_issue_mul),
        .dec  (w_in_busy),
        .cnt  (w_cnt),
        .last (w_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RUN;
        end else begin
            case (r_state)
                RUN:      if (w_issue_mul) r_state <= MUL_BUSY;
                MUL_BUSY: if (w_last)      r_state <= RUN;
                default:  r_state <= RUN;
            endcase
        end
    end

    // Reset holds everything in the free-running pass-through configuration
    always_comb begin
        PC_write    = 1'b1;
        IF_ID_write = 1'b1;
        IF_ID_flush = 1'b0;
        ID_EX_write = 1'b1;
        ID_EX_flush = 1'b0;
        EX_M_bubble = 1'b0;
        mul_start   = w_issue_mul;
        mul_busy    = w_in_busy;
        if (w_branch_flush) begin
            IF_ID_flush = 1'b1;
            ID_EX_flush = 1'b1;
        end else if (w_lu_stall) begin
            PC_write    = 1'b0;
            IF_ID_write = 1'b0;
            ID_EX_flush = 1'b1;
        end
        if (w_in_busy) begin
            PC_write    = 1'b0;
            IF_ID_write = 1'b0;
            ID_EX_write = 1'b0;
            EX_M_bubble = 1'b1;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= 32'd0;
            r_flush_cnt <= 32'd0;
        end else begin
            if ((w_lu_stall || w_in_busy) && (r_stall_cnt != 32'hFFFF_FFFF))
                r_stall_cnt <= r_stall_cnt + 32'd1;
            if (w_branch_flush && (r_flush_cnt != 32'hFFFF_FFFF))
                r_flush_cnt <= r_flush_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`else
    assign stall_cnt = 32'd0;
    assign flush_cnt = 32'd0;
`endif

endmodule
`default_nettype wire

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the five-stage MIPS core. It sits beside the forwarding unit and covers the hazards forwarding cannot resolve:
- load-use dependencies, by stalling one cycle and inserting a bubble;
- taken branches resolved in EX, by flushing IF/ID and ID/EX;
- multi-cycle multiplies, by freezing the front end for a fixed latency.

It drives the write enables and flush controls of PC, IF/ID, ID/EX and EX/M.

## Interface
- MUL_LAT, 4, multiply latency in cycles; legal range 2..16
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- ID_Rs  in  5  rs of the instruction in ID
- ID_Rt  in  5  rt of the instruction in ID
- ID_uses_rt  in  1  ID instruction reads rt as a source
- ID_is_mul  in  1  ID instruction is a multiply
- EX_MemRead  in  1  EX instruction is a load
- EX_WR_out  in  5  destination register of the EX instruction
- EX_branch_taken  in  1  branch in EX resolved taken
- PC_write  out  1  PC load enable
- IF_ID_write  out  1  IF/ID load enable
- IF_ID_flush  out  1  clear IF/ID to NOP
- ID_EX_write  out  1  ID/EX load enable
- ID_EX_flush  out  1  load NOP into ID/EX
- EX_M_bubble  out  1  load NOP into EX/M
- mul_start  out  1  one-cycle pulse; multiplier latches operands
- mul_busy  out  1  multiply in progress
- stall_cnt  out  32  load-use plus multiply stall cycles
- flush_cnt  out  32  branch flush events

## Operation
- States: RUN and MUL_BUSY.
- Countdown counter `cnt`, width $clog2(MUL_LAT).
- **Load-use hazard (`lu`)**: EX_MemRead && EX_WR_out!=0 && (EX_WR_out==ID_Rs || (ID_uses_rt && EX_WR_out==ID_Rt)).
- **RUN priority, highest first:**
  - EX_branch_taken:
    - IF_ID_flush=1, ID_EX_flush=1.
    - PC_write=1, IF_ID_write=1, ID_EX_write=1.
    - Suppresses `lu` and mul issue.
    - flush_cnt increments.
  - `lu`:
    - PC_write=0, IF_ID_write=0, ID_EX_flush=1, ID_EX_write=1.
    - stall_cnt increments.
  - ID_is_mul:
    - mul_start=1; the mul advances into ID/EX normally.
    - Next state MUL_BUSY, cnt <= MUL_LAT-1.
  - Otherwise: all enables 1, all flush/bubble/pulse outputs 0.
- **MUL_BUSY:**
  - PC_write=0, IF_ID_write=0, ID_EX_write=0, EX_M_bubble=1, mul_busy=1.
  - cnt decrements each cycle; stall_cnt increments each cycle.
  - When cnt==1: next state RUN; the enables are restored in the cycle the state is RUN.
- EX_branch_taken and `lu` are ignored in MUL_BUSY. EX holds the mul, so neither can legitimately assert.
- Outputs are combinational from state and inputs; state, cnt and the counters are registered.
- Counters saturate at 32'hFFFF_FFFF.

## Timing
- `lu` stall is exactly 1 cycle. The load moves to MEM, `lu` drops, and the forwarding unit supplies the value.
- Branch flush takes effect in the same cycle as EX_branch_taken. The fetch target is loaded that edge.
- Multiply:
  - mul_start is high in cycle T.
  - mul_busy is high in T+1..T+MUL_LAT-1, i.e. MUL_LAT-1 freeze cycles.
  - Pipeline advances again at T+MUL_LAT.
- Back-to-back muls: a mul in ID at exit issues on the first RUN cycle. No extra gap.
- Reset:
  - rst high at an edge forces RUN, cnt=0, stall_cnt=0, flush_cnt=0, overriding any other update.
  - Reset mid-multiply aborts it; mul_busy=0 the next cycle.
  - While rst is high, mul_start=0, and all enables are 1 with all flushes 0.

## Configuration
- Macro: HAZARD_PERF_EN.
- Defined: stall_cnt and flush_cnt counters are implemented as above.
- Undefined: no counter flops. stall_cnt and flush_cnt ports remain and are tied to 32'd0.

## Structure
- Package hazard_pkg contains:
  - state enum {RUN, MUL_BUSY};
  - MUL_LAT_MIN=2 and MUL_LAT_MAX=16, checked by an elaboration-time assertion;
  - NOP encoding constant shared with the pipeline registers.
- Sub-module mul_busy_cnt: load/decrement counter with a `last` flag, parameterised by MUL_LAT.

## Test plan
- lw $8 in EX; add reading $8 as rs in ID -> one cycle with PC_write=0, IF_ID_write=0, ID_EX_flush=1; stall_cnt 0->1.
- lw $0 in EX; add reading $0 in ID -> no stall.
- lw $8 in EX; addi with rt=$8 and ID_uses_rt=0 -> no stall.
- EX_branch_taken=1 together with a `lu` condition -> IF_ID_flush=1, ID_EX_flush=1, PC_write=1; flush_cnt=1; stall_cnt unchanged.
- MUL_LAT=4, mul in ID at T -> mul_start at T; mul_busy and EX_M_bubble at T+1..T+3; PC_write=1 at T+4; stall_cnt=3.
- rst asserted at T+2 of a multiply -> RUN and mul_busy=0 at T+3; counters read 0.
